// File: rtl/i_type_exec_unit_if.sv
// Request/response bundle between register-read, the I-type execute unit and writeback.
interface i_type_exec_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_rs1;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             busy;

    modport master (
        output in_valid, in_instr, in_rs1, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal, busy
    );

    modport slave (
        input  in_valid, in_instr, in_rs1, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal, busy
    );
endinterface

// File: rtl/i_type_exec_unit.sv
// Handshaked RV32I/RV64I OP-IMM execute unit with an iterative shifter and
// illegal-encoding detection; results are held in an output register until drained.
module i_type_exec_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    i_type_exec_unit_if.slave io_bus
);
    localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;
    localparam int unsigned CNT_W   = SHAMT_W + 2;
    localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [XLEN-1:0]  r_work;
    logic [CNT_W-1:0] r_rem;
    logic             r_left;
    logic             r_arith;
    logic [TAG_W-1:0] r_shift_tag;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_illegal;

    logic [2:0]         w_funct3;
    logic [XLEN-1:0]    w_imm;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_upper_clear;
    logic               w_is_shift;
    logic               w_illegal;
    logic               w_in_ready;
    logic               w_busy;
    logic               w_accept;
    logic               w_start_shift;
    logic [XLEN-1:0]    w_alu;
    logic [CNT_W-1:0]   w_k;
    logic [XLEN-1:0]    w_work_next;
    logic               w_shift_done;

    assign w_funct3 = io_bus.in_instr[14:12];
    assign w_imm    = {{(XLEN-12){io_bus.in_instr[31]}}, io_bus.in_instr[31:20]};
    assign w_shamt  = io_bus.in_instr[20 +: SHAMT_W];

    // Everything above shamt except instr[30] must be zero; instr[30] only selects SRAI
    assign w_upper_clear = ({io_bus.in_instr[31], io_bus.in_instr[29:20+SHAMT_W]} == '0);
    assign w_is_shift    = (w_funct3 == F3_SLL) || (w_funct3 == F3_SR);
    assign w_illegal     = ((w_funct3 == F3_SLL) && !(w_upper_clear && !io_bus.in_instr[30])) ||
                           ((w_funct3 == F3_SR)  && !w_upper_clear);
    assign w_accept      = io_bus.in_valid && w_in_ready;
    assign w_start_shift = w_accept && w_is_shift && !w_illegal && (w_shamt != '0);

    // Single-cycle ops; shifts only reach here with shamt == 0, so they pass rs1
    always_comb begin
        w_alu = io_bus.in_rs1;
        case (w_funct3)
            F3_ADD:  w_alu = io_bus.in_rs1 + w_imm;
            F3_SLT:  w_alu = XLEN'($signed(io_bus.in_rs1) < $signed(w_imm));
            F3_SLTU: w_alu = XLEN'(io_bus.in_rs1 < w_imm);
            F3_XOR:  w_alu = io_bus.in_rs1 ^ w_imm;
            F3_OR:   w_alu = io_bus.in_rs1 | w_imm;
            F3_AND:  w_alu = io_bus.in_rs1 & w_imm;
            default: w_alu = io_bus.in_rs1;
        endcase
    end

    assign w_k          = (r_rem < STEP) ? r_rem : STEP;
    assign w_shift_done = (r_rem == w_k);

    always_comb begin
        w_work_next = r_work >> w_k;
        if (r_left) begin
            w_work_next = r_work << w_k;
        end else if (r_arith) begin
            w_work_next = XLEN'($signed(r_work) >>> w_k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_shift) w_state_next = S_SHIFT;
            S_SHIFT: if (w_shift_done)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_in_ready = rst_n && (r_state == S_IDLE) && (!r_out_valid || io_bus.out_ready);
        w_busy     = (r_state == S_SHIFT);
    end

    // Shifter working registers and the output holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work        <= '0;
            r_rem         <= '0;
            r_left        <= 1'b0;
            r_arith       <= 1'b0;
            r_shift_tag   <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_tag     <= '0;
            r_out_illegal <= 1'b0;
        end else begin
            if (r_out_valid && io_bus.out_ready) r_out_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_start_shift) begin
                    r_work      <= io_bus.in_rs1;
                    r_rem       <= CNT_W'(w_shamt);
                    r_left      <= (w_funct3 == F3_SLL);
                    r_arith     <= io_bus.in_instr[30];
                    r_shift_tag <= io_bus.in_tag;
                end else if (w_accept) begin
                    r_out_valid   <= 1'b1;
                    r_out_result  <= w_illegal ? '0 : w_alu;
                    r_out_tag     <= io_bus.in_tag;
                    r_out_illegal <= w_illegal;
                end
            end else begin
                r_work <= w_work_next;
                r_rem  <= r_rem - w_k;
                if (w_shift_done) begin
                    r_out_valid   <= 1'b1;
                    r_out_result  <= w_work_next;
                    r_out_tag     <= r_shift_tag;
                    r_out_illegal <= 1'b0;
                end
            end
        end
    end

    assign io_bus.in_ready    = w_in_ready;
    assign io_bus.busy        = w_busy;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_result  = r_out_result;
    assign io_bus.out_tag     = r_out_tag;
    assign io_bus.out_illegal = r_out_illegal;
endmodule
